// File: rtl/swg_input_writer_pkg.sv
// Shared types for the sliding window generator write side.
package swg_input_writer_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wstate_e;

endpackage

// File: rtl/swg_occupancy_counter.sv
// Occupancy tracker: +inc / -dec per cycle, clamped to [0, MAX], sticky underflow flag.
module swg_occupancy_counter #(
  parameter int unsigned MAX = 16,
  parameter int unsigned CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [CW-1:0] dec,
  output logic [CW-1:0] level,
  output logic [CW-1:0] level_next_c,
  output logic          underflow
);

  localparam logic signed [CW:0] MAX_S = $signed((CW + 1)'(MAX));

  logic signed [CW:0] sum_c;

  // Net update at one extra bit so a release larger than the level shows up as negative.
  always_comb begin
    sum_c = $signed({1'b0, level}) + $signed({{CW{1'b0}}, inc}) - $signed({1'b0, dec});
    if (sum_c[CW]) begin
      level_next_c = '0;
    end else if (sum_c > MAX_S) begin
      level_next_c = CW'(MAX);
    end else begin
      level_next_c = sum_c[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level     <= '0;
      underflow <= 1'b0;
    end else begin
      level <= level_next_c;
      if (sum_c[CW]) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/swg_input_writer.sv
// Write-side front end of the sliding window generator: stream in, cyclic buffer writes,
// occupancy tracking and fill/run/drain frame sequencing.
module swg_input_writer
  import swg_input_writer_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned PREFILL         = 8,
  parameter int unsigned ELEMS_PER_FRAME = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [$clog2(DEPTH+1)-1:0]   release_count,
  output logic                         wr_en,
  output logic [$clog2(DEPTH)-1:0]     wr_addr,
  output logic [WIDTH-1:0]             wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         rd_start,
  output logic                         frame_done,
  output logic                         err_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = (ELEMS_PER_FRAME > 1) ? $clog2(ELEMS_PER_FRAME) : 1;

  wstate_e       state, state_n;
  logic [AW-1:0] addr;
  logic [EW-1:0] elem_cnt;
  logic          ready_q;
  logic          accept_c;
  logic          last_c;
  logic [CW-1:0] level_n;

  assign accept_c   = s_tvalid & ready_q;
  assign last_c     = accept_c && (elem_cnt == EW'(ELEMS_PER_FRAME - 1));
  assign s_tready   = ready_q;
  assign wr_en      = accept_c;
  assign wr_data    = s_tdata;
  assign wr_addr    = addr;
  assign rd_start   = (state != ST_FILL);
  assign frame_done = (state == ST_DRAIN) && (fill_level == '0);

  swg_occupancy_counter #(
    .MAX (DEPTH),
    .CW  (CW)
  ) u_occ (
    .clk          (clk),
    .rst          (rst),
    .inc          (accept_c),
    .dec          (release_count),
    .level        (fill_level),
    .level_next_c (level_n),
    .underflow    (err_underflow)
  );

  // Frame sequencing; the last accept of a frame wins over the prefill threshold.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_FILL: begin
        if (last_c)                          state_n = ST_DRAIN;
        else if (fill_level >= CW'(PREFILL)) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (last_c) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fill_level == '0) state_n = ST_FILL;
      end
      default: state_n = ST_FILL;
    endcase
  end

  // Ready is registered from next-state values so it never depends on s_tvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      ready_q  <= 1'b0;
      addr     <= '0;
      elem_cnt <= '0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != ST_DRAIN) && (level_n < CW'(DEPTH));
      if (accept_c) begin
        addr <= (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
      end
      if (last_c) begin
        elem_cnt <= '0;
      end else if (accept_c) begin
        elem_cnt <= elem_cnt + 1'b1;
      end
    end
  end

endmodule
